// File: rtl/riscv_pkg.sv
// Shared RV32I execute-stage types: uop classes, ALU opcodes, sequencer states
// and small class-decoding helpers used by the execute control block.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OC_R    = 3'd0,
    OC_I    = 3'd1,
    OC_S    = 3'd2,
    OC_L    = 3'd3,
    OC_B    = 3'd4,
    OC_JAL  = 3'd5,
    OC_JALR = 3'd6,
    OC_LUI  = 3'd7
  } opclass_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_BEQ  = 4'd10,
    ALU_BNE  = 4'd11,
    ALU_BLT  = 4'd12,
    ALU_BGE  = 4'd13,
    ALU_BLTU = 4'd14,
    ALU_BGEU = 4'd15
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MREQ  = 3'd2,
    ST_MWAIT = 3'd3,
    ST_WB    = 3'd4
  } state_t;

  typedef struct packed {
    opclass_t   cls;
    alu_op_t    op;
    logic [4:0] rd;
  } uop_ctl_t;

  function automatic logic is_mem(input opclass_t cls);
    return (cls == OC_L) || (cls == OC_S);
  endfunction

  function automatic logic is_jump(input opclass_t cls);
    return (cls == OC_JAL) || (cls == OC_JALR);
  endfunction

  // Classes whose result is produced directly at the end of EXEC.
  function automatic logic exec_writes_rd(input opclass_t cls);
    return (cls == OC_R) || (cls == OC_I) || (cls == OC_LUI) || is_jump(cls);
  endfunction

endpackage

// File: rtl/exec_opnd_sel.sv
// Combinational operand selection for the external ALU, plus the link value
// and the redirect target of branches and jumps.
module exec_opnd_sel
  import riscv_pkg::*;
#(
  parameter int W = XLEN_DEFAULT
) (
  input  opclass_t       cls,
  input  alu_op_t        op_in,
  input  logic [W-1:0]   rs1,
  input  logic [W-1:0]   rs2,
  input  logic [W-1:0]   imm,
  input  logic [W-1:0]   pc,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output alu_op_t        alu_op,
  output logic [W-1:0]   link,
  output logic [W-1:0]   target
);

  logic [W-1:0] four_s;
  logic [W-1:0] jalr_sum_s;

  assign four_s     = W'(32'd4);
  assign jalr_sum_s = rs1 + imm;
  assign link       = pc + four_s;

  // Operand routing by uop class; address-forming classes force an add.
  always_comb begin
    alu_a  = rs1;
    alu_b  = rs2;
    alu_op = op_in;
    case (cls)
      OC_R, OC_B: begin
        alu_a  = rs1;
        alu_b  = rs2;
        alu_op = op_in;
      end
      OC_I: begin
        alu_a  = rs1;
        alu_b  = imm;
        alu_op = op_in;
      end
      OC_L, OC_S: begin
        alu_a  = rs1;
        alu_b  = imm;
        alu_op = ALU_ADD;
      end
      OC_LUI: begin
        alu_a  = '0;
        alu_b  = imm;
        alu_op = ALU_ADD;
      end
      OC_JAL, OC_JALR: begin
        alu_a  = pc;
        alu_b  = four_s;
        alu_op = ALU_ADD;
      end
      default: begin
        alu_a  = rs1;
        alu_b  = rs2;
        alu_op = op_in;
      end
    endcase
  end

  // JALR clears bit 0 of its target; everything else is PC-relative.
  always_comb begin
    if (cls == OC_JALR) begin
      target = jalr_sum_s & ~W'(32'd1);
    end else begin
      target = pc + imm;
    end
  end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: latches one decoded uop, drives the external ALU,
// sequences data-memory traffic, issues redirects and hands results to writeback.
module alu_exec_ctrl
  import riscv_pkg::*;
#(
  parameter int          XLEN   = XLEN_DEFAULT,
  parameter logic [31:0] PC_RST = 32'd0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [2:0]      id_class,
  input  logic [3:0]      id_alu_op,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1,
  input  logic [XLEN-1:0] id_rs2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_taken,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  state_t          state_q, state_d;
  uop_ctl_t        ctl_q, ctl_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, pc_q, pc_d;
  logic            id_ready_q, id_ready_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            accept_s, exec_s, rsp_s;
  alu_op_t         alu_op_s;
  logic [XLEN-1:0] link_s, target_s;

  assign accept_s = (state_q == ST_IDLE) && id_valid && id_ready_q;
  assign exec_s   = (state_q == ST_EXEC);
  assign rsp_s    = (state_q == ST_MWAIT) && mem_rsp_valid;

  exec_opnd_sel #(.W(XLEN)) u_opnd_sel (
    .cls    (ctl_q.cls),
    .op_in  (ctl_q.op),
    .rs1    (rs1_q),
    .rs2    (rs2_q),
    .imm    (imm_q),
    .pc     (pc_q),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op_s),
    .link   (link_s),
    .target (target_s)
  );

  // State register together with the latched uop and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      ctl_q            <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      imm_q            <= '0;
      pc_q             <= '0;
      id_ready_q       <= 1'b1;
      mem_req_valid_q  <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      wb_valid_q       <= 1'b0;
      wb_rd_q          <= 5'd0;
      wb_data_q        <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      ctl_q            <= ctl_d;
      rs1_q            <= rs1_d;
      rs2_q            <= rs2_d;
      imm_q            <= imm_d;
      pc_q             <= pc_d;
      id_ready_q       <= id_ready_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      wb_valid_q       <= wb_valid_d;
      wb_rd_q          <= wb_rd_d;
      wb_data_q        <= wb_data_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // Next-state logic; a destination of x0 skips the writeback handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = accept_s ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        if (is_mem(ctl_q.cls)) begin
          state_d = ST_MREQ;
        end else if (exec_writes_rd(ctl_q.cls) && (ctl_q.rd != 5'd0)) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MREQ: begin
        if (mem_req_ready) begin
          state_d = (ctl_q.cls == OC_S) ? ST_IDLE : ST_MWAIT;
        end else begin
          state_d = ST_MREQ;
        end
      end
      ST_MWAIT: begin
        if (mem_rsp_valid) begin
          state_d = (ctl_q.rd != 5'd0) ? ST_WB : ST_IDLE;
        end else begin
          state_d = ST_MWAIT;
        end
      end
      ST_WB:    state_d = wb_ready ? ST_IDLE : ST_WB;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; everything holds unless its producing state fires.
  always_comb begin
    ctl_d.cls = accept_s ? opclass_t'(id_class) : ctl_q.cls;
    ctl_d.op  = accept_s ? alu_op_t'(id_alu_op) : ctl_q.op;
    ctl_d.rd  = accept_s ? id_rd  : ctl_q.rd;
    rs1_d     = accept_s ? id_rs1 : rs1_q;
    rs2_d     = accept_s ? id_rs2 : rs2_q;
    imm_d     = accept_s ? id_imm : imm_q;
    pc_d      = accept_s ? id_pc  : pc_q;

    if (exec_s && is_mem(ctl_q.cls)) begin
      mem_we_d    = (ctl_q.cls == OC_S);
      mem_addr_d  = alu_res;
      mem_wdata_d = rs2_q;
    end else begin
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
    end
    mem_req_valid_d = (state_d == ST_MREQ);

    if (exec_s && exec_writes_rd(ctl_q.cls)) begin
      wb_rd_d   = ctl_q.rd;
      wb_data_d = is_jump(ctl_q.cls) ? link_s : alu_res;
    end else if (rsp_s) begin
      wb_rd_d   = ctl_q.rd;
      wb_data_d = mem_rsp_data;
    end else begin
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
    end
    wb_valid_d = (state_d == ST_WB);

    redirect_valid_d = exec_s && (is_jump(ctl_q.cls) || ((ctl_q.cls == OC_B) && alu_taken));
    redirect_pc_d    = redirect_valid_d ? target_s : redirect_pc_q;

    // Decode must not hand over a uop while it is flushing on a redirect.
    id_ready_d = (state_d == ST_IDLE) && !redirect_valid_d;
  end

  assign id_ready       = id_ready_q;
  assign alu_op         = alu_op_s;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: bench-side ALU, transaction-level reference model
// checked every cycle, directed scenarios with literal values, then random traffic.
module tb_alu_exec_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        id_valid = 1'b0, id_ready;
  logic [2:0]  id_class = 3'd0;
  logic [3:0]  id_alu_op = 4'd0, alu_op;
  logic [4:0]  id_rd = 5'd0, wb_rd;
  logic [31:0] id_rs1 = 32'd0, id_rs2 = 32'd0, id_imm = 32'd0, id_pc = 32'd0;
  logic [31:0] alu_a, alu_b, alu_res, mem_addr, mem_wdata, wb_data, redirect_pc;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        alu_taken, mem_req_valid, mem_we, wb_valid, redirect_valid;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0, wb_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready),
    .id_class(id_class), .id_alu_op(id_alu_op), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_imm(id_imm), .id_pc(id_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res), .alu_taken(alu_taken),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic cmp_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_BEQ:  return a == b;
      ALU_BNE:  return a != b;
      ALU_BLT:  return $signed(a) < $signed(b);
      ALU_BGE:  return $signed(a) >= $signed(b);
      ALU_BLTU: return a < b;
      ALU_BGEU: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction

  always_comb begin
    alu_res   = alu_fn(alu_op, alu_a, alu_b);
    alu_taken = cmp_fn(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: where the uop is in its life, tracked per cycle.
  bit          m_idle = 1'b1, m_exec = 1'b0, m_mem = 1'b0, m_rsp = 1'b0, m_wb = 1'b0, m_redir = 1'b0;
  bit          u_wb, u_mem, u_redir;
  logic [2:0]  u_cls;
  logic [3:0]  u_op;
  logic [4:0]  u_rd;
  logic [31:0] u_rs1, u_rs2, u_imm, u_pc, e_wb_data, e_redir_pc;

  always @(negedge clk) begin
    bit          redir_now;
    logic [31:0] ea, eb;
    logic [3:0]  eop;
    if (rst) begin
      chk("rst id_ready", id_ready, 1);
      chk("rst wb_valid", wb_valid, 0);
      chk("rst mem_req_valid", mem_req_valid, 0);
      chk("rst redirect_valid", redirect_valid, 0);
      chk("rst data", wb_data | mem_addr | mem_wdata | redirect_pc | alu_a | alu_b, 0);
      chk("rst small", {wb_rd, alu_op, mem_we}, 0);
      m_idle = 1'b1; m_exec = 1'b0; m_mem = 1'b0; m_rsp = 1'b0; m_wb = 1'b0; m_redir = 1'b0;
    end else begin
      redir_now = m_redir;
      chk("id_ready", id_ready, m_idle && !redir_now);
      chk("redirect_valid", redirect_valid, redir_now);
      if (redir_now) chk("redirect_pc", redirect_pc, e_redir_pc);
      chk("wb_valid", wb_valid, m_wb);
      if (m_wb) begin
        chk("wb_rd", wb_rd, u_rd);
        chk("wb_data", wb_data, e_wb_data);
      end
      chk("mem_req_valid", mem_req_valid, m_mem);
      if (m_mem) begin
        chk("mem_we", mem_we, u_cls == OC_S);
        chk("mem_addr", mem_addr, u_rs1 + u_imm);
        chk("mem_wdata", mem_wdata, u_rs2);
      end
      if (m_exec) begin
        case (u_cls)
          OC_R, OC_B:  begin ea = u_rs1; eb = u_rs2; eop = u_op;    end
          OC_I:        begin ea = u_rs1; eb = u_imm; eop = u_op;    end
          OC_L, OC_S:  begin ea = u_rs1; eb = u_imm; eop = ALU_ADD; end
          OC_LUI:      begin ea = 32'd0; eb = u_imm; eop = ALU_ADD; end
          default:     begin ea = u_pc;  eb = 32'd4; eop = ALU_ADD; end
        endcase
        chk("alu_a", alu_a, ea);
        chk("alu_b", alu_b, eb);
        chk("alu_op", alu_op, eop);
      end
      m_redir = 1'b0;
      if (m_exec) begin
        m_exec = 1'b0;
        m_redir = u_redir;
        if (u_mem) m_mem = 1'b1;
        else if (u_wb) m_wb = 1'b1;
        else m_idle = 1'b1;
      end else if (m_rsp && mem_rsp_valid) begin
        m_rsp = 1'b0;
        e_wb_data = mem_rsp_data;
        if (u_rd != 5'd0) m_wb = 1'b1;
        else m_idle = 1'b1;
      end else if (m_mem && mem_req_ready) begin
        m_mem = 1'b0;
        if (u_cls == OC_S) m_idle = 1'b1;
        else m_rsp = 1'b1;
      end else if (m_wb && wb_ready) begin
        m_wb = 1'b0;
        m_idle = 1'b1;
      end else if (m_idle && !redir_now && id_valid) begin
        m_idle = 1'b0;
        m_exec = 1'b1;
        u_cls = id_class; u_op = id_alu_op; u_rd = id_rd;
        u_rs1 = id_rs1; u_rs2 = id_rs2; u_imm = id_imm; u_pc = id_pc;
        case (id_class)
          OC_R:             e_wb_data = alu_fn(id_alu_op, id_rs1, id_rs2);
          OC_I:             e_wb_data = alu_fn(id_alu_op, id_rs1, id_imm);
          OC_LUI:           e_wb_data = id_imm;
          OC_JAL, OC_JALR:  e_wb_data = id_pc + 32'd4;
          default:          e_wb_data = 32'd0;
        endcase
        u_mem   = (id_class == OC_L) || (id_class == OC_S);
        u_wb    = (id_rd != 5'd0) && (id_class inside {OC_R, OC_I, OC_LUI, OC_JAL, OC_JALR});
        u_redir = (id_class == OC_JAL) || (id_class == OC_JALR) ||
                  ((id_class == OC_B) && cmp_fn(id_alu_op, id_rs1, id_rs2));
        e_redir_pc = (id_class == OC_JALR) ? ((id_rs1 + id_imm) & 32'hFFFF_FFFE) : (id_pc + id_imm);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return wb_valid;
      1:       return redirect_valid;
      2:       return mem_req_valid;
      default: return id_ready;
    endcase
  endfunction

  task automatic wait_until(input int which, input string nm);
    int n = 0;
    while (!sel(which) && n < 20) begin
      tick();
      n++;
    end
    chk(nm, sel(which), 1);
  endtask

  task automatic issue(input logic [2:0] c, input logic [3:0] op, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    id_class = c; id_alu_op = op; id_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_imm = imm; id_pc = pc;
    id_valid = 1'b1;
    wait_until(3, "issue id_ready");
    tick();
    id_valid = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // ADD 5+7
    issue(OC_R, ALU_ADD, 5'd3, 32'd5, 32'd7, 32'd0, 32'd0);
    wait_until(0, "add wb_valid");
    chk("add wb_data", wb_data, 32'd12);
    chk("add wb_rd", wb_rd, 32'd3);
    tick();

    // BEQ taken backwards
    issue(OC_B, ALU_BEQ, 5'd0, 32'd3, 32'd3, 32'hFFFF_FFF8, 32'h100);
    wait_until(1, "beq redirect");
    chk("beq redirect_pc", redirect_pc, 32'hF8);
    chk("beq no wb", wb_valid, 0);
    tick();

    // LW with request backpressure
    mem_req_ready = 1'b0;
    issue(OC_L, ALU_XOR, 5'd5, 32'h1000, 32'd0, 32'd4, 32'h200);
    wait_until(2, "lw mem_req_valid");
    for (int i = 0; i < 3; i++) begin
      chk("lw mem_addr held", mem_addr, 32'h1004);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    wait_until(0, "lw wb_valid");
    chk("lw wb_data", wb_data, 32'hDEAD_BEEF);
    tick();

    // SW under backpressure
    issue(OC_S, ALU_ADD, 5'd9, 32'h2000, 32'hCAFE_F00D, 32'd8, 32'h204);
    wait_until(2, "sw mem_req_valid");
    for (int i = 0; i < 4; i++) begin
      chk("sw mem_wdata held", mem_wdata, 32'hCAFE_F00D);
      chk("sw mem_we", mem_we, 1);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("sw id_ready", id_ready, 1);
    chk("sw no wb", wb_valid, 0);

    // JALR with writeback stall
    wb_ready = 1'b0;
    issue(OC_JALR, ALU_SUB, 5'd1, 32'h203, 32'd0, 32'd0, 32'h40);
    wait_until(1, "jalr redirect");
    chk("jalr redirect_pc", redirect_pc, 32'h202);
    for (int i = 0; i < 5; i++) begin
      chk("jalr wb held", {wb_valid, wb_data[30:0]}, {1'b1, 31'h44});
      tick();
    end
    wb_ready = 1'b1;
    tick();

    // Reset while waiting for load data, then a late response
    issue(OC_L, ALU_ADD, 5'd6, 32'h3000, 32'd0, 32'd0, 32'h300);
    wait_until(2, "rst-lw mem_req_valid");
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk("late rsp ignored", wb_valid, 0);
    issue(OC_R, ALU_ADD, 5'd7, 32'd10, 32'd20, 32'd0, 32'd0);
    wait_until(0, "post-rst wb_valid");
    chk("post-rst wb_data", wb_data, 32'd30);
    tick();

    // Random traffic, occasional resets
    for (int i = 0; i < 4000; i++) begin
      id_valid      = 1'($urandom_range(0, 1));
      id_class      = 3'($urandom_range(0, 7));
      id_alu_op     = 4'($urandom_range(0, 15));
      id_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      id_rs1        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      id_rs2        = ($urandom_range(0, 3) == 0) ? id_rs1 : $urandom;
      id_imm        = $urandom;
      id_pc         = $urandom;
      wb_ready      = ($urandom_range(0, 3) != 0);
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_data  = $urandom;
      rst           = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    id_valid = 1'b0;
    wb_ready = 1'b1;
    mem_req_ready = 1'b1;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
